// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write path to the external DAC.
// Holds the FSM state encoding, quarter-phase names and the bus-drive decode.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_CTRL,
        ST_ACK2,
        ST_DATA,
        ST_ACK3,
        ST_STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int SYMBOLS_PER_WRITE = 29;
    localparam int TICKS_PER_SYMBOL  = 4;

    // Returns {scl_low, sda_low} for a given symbol, quarter and data bit.
    function automatic logic [1:0] bus_drive(state_t st, logic [1:0] qtr, logic bit_val);
        logic scl_low;
        logic sda_low;
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (st)
            ST_START: sda_low = (qtr >= Q2);
            ST_ADDR, ST_CTRL, ST_DATA: begin
                scl_low = (qtr <= Q1);
                sda_low = ~bit_val;
            end
            ST_ACK1, ST_ACK2, ST_ACK3: scl_low = (qtr <= Q1);
            ST_STOP: begin
                scl_low = (qtr <= Q1);
                sda_low = (qtr != Q3);
            end
            default: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
        endcase
        return {scl_low, sda_low};
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// SCL quarter-period divider: one-cycle tick every CLK_DIV clocks while enabled.
// Counter restarts from zero whenever the enable drops, so each frame starts aligned.
module i2c_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/i2c_dac_transmitter.sv
// Single-write I2C master for the waveform DAC: START, addr+W, control, sample, STOP.
// Open-drain SCL/SDA are driven through registered output enables only.
module i2c_dac_transmitter
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV   = 25,
    parameter logic [6:0] DAC_ADDR  = 7'h48,
    parameter logic [7:0] CTRL_BYTE = 8'h40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       busy,
    output logic       ack_error
);

    state_t     state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sample_q;
    logic       busy_q, ready_q, ack_err_q, ack_samp_q;
    logic       scl_oe_q, sda_oe_q;
    logic       tick, accept, ack_slot_q2_end;
    logic [7:0] tx_byte_d;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (busy_q),
        .tick  (tick)
    );

    assign accept = sample_valid && ready_q;
    assign ack_slot_q2_end = tick && (qtr_q == Q2) &&
                             (state_q == ST_ACK1 || state_q == ST_ACK2 || state_q == ST_ACK3);

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                state_d = ST_START;
                qtr_d   = Q0;
                bit_d   = 3'd7;
            end
        end else if (tick) begin
            if (qtr_q != Q3) begin
                qtr_d = qtr_q + 2'd1;
            end else begin
                qtr_d = Q0;
                bit_d = bit_q - 3'd1;
                case (state_q)
                    ST_START: begin
                        state_d = ST_ADDR;
                        bit_d   = 3'd7;
                    end
                    ST_ADDR: if (bit_q == 3'd0) state_d = ST_ACK1;
                    ST_CTRL: if (bit_q == 3'd0) state_d = ST_ACK2;
                    ST_DATA: if (bit_q == 3'd0) state_d = ST_ACK3;
                    // A NACK seen in this slot skips the rest of the frame.
                    ST_ACK1: begin
                        state_d = ack_err_q ? ST_STOP : ST_CTRL;
                        bit_d   = 3'd7;
                    end
                    ST_ACK2: begin
                        state_d = ack_err_q ? ST_STOP : ST_DATA;
                        bit_d   = 3'd7;
                    end
                    ST_ACK3: state_d = ST_STOP;
                    ST_STOP: state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (state_d)
            ST_ADDR: tx_byte_d = {DAC_ADDR, 1'b0};
            ST_CTRL: tx_byte_d = CTRL_BYTE;
            ST_DATA: tx_byte_d = sample_q;
            default: tx_byte_d = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            qtr_q      <= Q0;
            bit_q      <= 3'd7;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            ack_err_q  <= 1'b0;
            ack_samp_q <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            busy_q     <= (state_d != ST_IDLE);
            ready_q    <= (state_d == ST_IDLE);
            {scl_oe_q, sda_oe_q} <= bus_drive(state_d, qtr_d, tx_byte_d[bit_d]);
            // ack_samp_q marks the first cycle of an ACK slot's q3.
            ack_samp_q <= ack_slot_q2_end;
            if (accept) begin
                ack_err_q <= 1'b0;
            end else if (ack_samp_q && sda_in) begin
                ack_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sample_q <= sample;
        end
    end

    assign sample_ready = ready_q;
    assign busy         = busy_q;
    assign ack_error    = ack_err_q;
    assign scl_oe       = scl_oe_q;
    assign sda_oe       = sda_oe_q;

endmodule

// File: tb/tb_i2c_dac_transmitter.sv
// Bench for i2c_dac_transmitter: directed samples, bus decoder with ACKing slave,
// and a scoreboard of expected bus events, frame lengths and reset states.
`timescale 1ns/1ps
module tb_i2c_dac_transmitter;

    localparam int CLK_DIV   = 4;
    localparam int FULL_LEN  = 464;   // 116 ticks * 4 clocks
    localparam int NACK1_LEN = 176;   // 44 ticks * 4 clocks

    localparam logic [3:0] EV_START   = 4'd1;
    localparam logic [3:0] EV_BYTE    = 4'd2;
    localparam logic [3:0] EV_STOP    = 4'd3;
    localparam logic [3:0] EV_LEN     = 4'd4;
    localparam logic [3:0] EV_RST     = 4'd5;
    localparam logic [3:0] EV_GAP     = 4'd6;
    localparam logic [3:0] EV_TIMEOUT = 4'd7;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sample = 8'h00;
    logic       sample_valid = 1'b0;
    logic       sample_ready, scl_oe, sda_oe, busy, ack_error, sda_in;
    logic       slave_pull = 1'b0;
    logic [6:0] slave_addr = 7'h48;
    logic       done = 1'b0;

    ev_t exp_q[$];
    int  rd_idx = 0;
    int  n_vec = 0;
    int  n_miss = 0;

    assign sda_in = ~sda_oe & ~slave_pull;

    always #5 clk = ~clk;

    i2c_dac_transmitter #(
        .CLK_DIV   (CLK_DIV),
        .DAC_ADDR  (7'h48),
        .CTRL_BYTE (8'h40)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .scl_oe       (scl_oe),
        .sda_oe       (sda_oe),
        .sda_in       (sda_in),
        .busy         (busy),
        .ack_error    (ack_error)
    );

    function automatic string ev_name(input logic [3:0] k);
        case (k)
            EV_START:   return "start";
            EV_BYTE:    return "byte";
            EV_STOP:    return "stop";
            EV_LEN:     return "frame_len";
            EV_RST:     return "reset_state";
            EV_GAP:     return "bus_gap";
            EV_TIMEOUT: return "timeout";
            default:    return "unknown";
        endcase
    endfunction

    // ---------------- stimulus ----------------
    task automatic push(input logic [3:0] k, input int d);
        ev_t e;
        e.kind = k;
        e.data = d[15:0];
        exp_q.push_back(e);
    endtask

    // LEN data packs cycles*2 + ack_error; BYTE data packs {ack, byte}.
    task automatic push_full(input logic [7:0] b);
        push(EV_START, 0);
        push(EV_BYTE, 16'h0090);
        push(EV_BYTE, 16'h0040);
        push(EV_BYTE, {8'h00, b});
        push(EV_STOP, 0);
        push(EV_LEN, FULL_LEN * 2);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_ready(input int max);
        int n;
        n = 0;
        while (!sample_ready && n < max) begin
            step();
            n++;
        end
        if (!sample_ready) push(EV_TIMEOUT, n);
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready(2000);
        sample       = b;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        push(EV_RST, 16'h0002);
        idle(4);
        reset = 1'b0;
        idle(5);

        push_full(8'hA5);
        send(8'hA5);
        wait_ready(1000);
        idle(20);

        slave_addr = 7'h21;
        push(EV_START, 0);
        push(EV_BYTE, 16'h0190);
        push(EV_STOP, 0);
        push(EV_LEN, NACK1_LEN * 2 + 1);
        send(8'h11);
        wait_ready(1000);
        idle(20);

        slave_addr = 7'h48;
        push_full(8'h66);
        send(8'h66);
        wait_ready(1000);
        idle(20);

        // Back-to-back: valid held, second sample taken the cycle ready returns.
        push_full(8'h00);
        push(EV_GAP, 9);    // accept cycle + START q0-q1 (8 clocks)
        push_full(8'hFF);
        wait_ready(1000);
        sample       = 8'h00;
        sample_valid = 1'b1;
        step();
        sample = 8'hFF;
        wait_ready(1000);
        step();
        sample_valid = 1'b0;
        wait_ready(1000);
        idle(20);

        push_full(8'h3C);
        send(8'h3C);
        idle(100);
        sample       = 8'h77;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        wait_ready(1000);
        idle(40);

        // Reset lands inside the DATA byte (DATA starts 304 clocks in).
        push(EV_START, 0);
        push(EV_BYTE, 16'h0090);
        push(EV_BYTE, 16'h0040);
        push(EV_RST, 16'h0002);
        send(8'h5A);
        idle(340);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(5);

        push_full(8'hC3);
        send(8'hC3);
        wait_ready(1000);
        idle(20);

        done = 1'b1;
    end

    // ---------------- monitor / slave model ----------------
    int         cycn = 0;
    int         rst_cnt = 0;
    int         bitcnt = 0;
    int         bytecnt = 0;
    int         t0 = 0;
    int         last_rise = -1000;
    logic       addressed = 1'b0;
    logic       frame_open = 1'b0;
    logic [7:0] shreg = 8'h00;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       prev_busy = 1'b0;
    logic       prev_ready = 1'b1;

    task automatic observe(input logic [3:0] k, input int d);
        n_vec++;
        if (rd_idx >= exp_q.size()) begin
            n_miss++;
            $display("FAIL %s: observed data=0x%0h but no event was expected", ev_name(k), d);
        end else begin
            if (exp_q[rd_idx].kind != k || exp_q[rd_idx].data != d[15:0]) begin
                n_miss++;
                $display("FAIL %s: got %s data=0x%0h, expected %s data=0x%0h", ev_name(k),
                         ev_name(k), d, ev_name(exp_q[rd_idx].kind), exp_q[rd_idx].data);
            end
            rd_idx++;
        end
    endtask

    always @(negedge clk) begin
        logic scl_l;
        logic sda_l;
        cycn++;
        scl_l = ~scl_oe;
        sda_l = sda_in;
        if (reset) begin
            rst_cnt++;
            if (rst_cnt == 2)
                observe(EV_RST, {11'd0, scl_oe, sda_oe, busy, sample_ready, ack_error});
            bitcnt     = 0;
            slave_pull = 1'b0;
            frame_open = 1'b0;
            last_rise  = -1000;
        end else begin
            rst_cnt = 0;
            if (scl_l && prev_scl && prev_sda && !sda_l) begin
                if (cycn - last_rise <= 12) observe(EV_GAP, cycn - last_rise);
                observe(EV_START, 0);
                bitcnt    = 0;
                bytecnt   = 0;
                addressed = 1'b0;
            end else if (scl_l && prev_scl && !prev_sda && sda_l) begin
                observe(EV_STOP, 0);
                bitcnt     = 0;
                slave_pull = 1'b0;
            end else if (scl_l && !prev_scl) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], sda_l};
                    bitcnt++;
                end else begin
                    observe(EV_BYTE, {7'd0, sda_l, shreg});
                    bitcnt = 0;
                    bytecnt++;
                end
            end else if (!scl_l && prev_scl) begin
                if (bitcnt == 8) begin
                    if (bytecnt == 0) addressed = (shreg == {slave_addr, 1'b0});
                    slave_pull = addressed;
                end else begin
                    slave_pull = 1'b0;
                end
            end
            if (busy && !prev_busy) begin
                frame_open = 1'b1;
                t0 = cycn;
            end
            if (sample_ready && !prev_ready && frame_open) begin
                observe(EV_LEN, (cycn - t0) * 2 + int'(ack_error));
                frame_open = 1'b0;
                last_rise  = cycn;
            end
        end
        prev_scl   = scl_l;
        prev_sda   = sda_l;
        prev_busy  = busy;
        prev_ready = sample_ready;

        if (done || cycn > 30000) begin
            if (!done) begin
                n_vec++;
                n_miss++;
                $display("FAIL watchdog: got %0d cycles without completion, required under 30000", cycn);
            end
            while (rd_idx < exp_q.size()) begin
                n_vec++;
                n_miss++;
                $display("FAIL %s: got nothing, expected data=0x%0h", ev_name(exp_q[rd_idx].kind),
                         exp_q[rd_idx].data);
                rd_idx++;
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
            $finish;
        end
    end

endmodule
